// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: queues results from the RS/ALU and the load/store buffer
// and broadcasts at most one per cycle to the ROB and wakeup logic, round-robin.
module cdb_arbiter #(
  parameter int ROB_WIDTH  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush,
  input  logic                  rs_valid,
  output logic                  rs_ready,
  input  logic [ROB_WIDTH-1:0]  rs_rob_id,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic                  rs_set_jump_addr,
  input  logic                  lsb_valid,
  output logic                  lsb_ready,
  input  logic [ROB_WIDTH-1:0]  lsb_rob_id,
  input  logic [DATA_WIDTH-1:0] lsb_data,
  output logic                  cdb_en,
  output logic [ROB_WIDTH-1:0]  cdb_rob_id,
  output logic [DATA_WIDTH-1:0] cdb_data,
  output logic                  cdb_set_jump_addr,
  output logic                  cdb_src
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {SRC_RS = 1'b0, SRC_LSB = 1'b1} src_e;

  typedef struct packed {
    logic [ROB_WIDTH-1:0]  rob_id;
    logic [DATA_WIDTH-1:0] data;
    logic                  jump;
  } entry_t;

  entry_t            rs_mem  [FIFO_DEPTH];
  entry_t            lsb_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rs_wr_ptr, rs_rd_ptr, lsb_wr_ptr, lsb_rd_ptr;
  logic [CNT_W-1:0]  rs_count, lsb_count;
  src_e              last_grant;

  logic active;
  logic rs_push, lsb_push, rs_pop, lsb_pop;
  logic grant_rs, grant_lsb;
  entry_t rs_head, lsb_head;

  assign active    = rdy_in & ~flush;
  assign rs_ready  = active & (rs_count  < CNT_W'(FIFO_DEPTH));
  assign lsb_ready = active & (lsb_count < CNT_W'(FIFO_DEPTH));
  assign rs_push   = rs_valid  & rs_ready;
  assign lsb_push  = lsb_valid & lsb_ready;
  assign rs_head   = rs_mem[rs_rd_ptr];
  assign lsb_head  = lsb_mem[lsb_rd_ptr];

  // Grant looks only at pre-edge occupancy, so a fresh push never bypasses its queue.
  always_comb begin
    grant_rs  = 1'b0;
    grant_lsb = 1'b0;
    if (rs_count != '0 && lsb_count != '0) begin
      if (last_grant == SRC_LSB) grant_rs  = 1'b1;
      else                       grant_lsb = 1'b1;
    end else if (rs_count != '0) begin
      grant_rs = 1'b1;
    end else if (lsb_count != '0) begin
      grant_lsb = 1'b1;
    end
  end

  assign rs_pop  = active & grant_rs;
  assign lsb_pop = active & grant_lsb;

  // NOTE: queue storage has no reset; pointers and counts alone define what is valid,
  // which keeps the array in plain RAM/flop cells without a reset tree.
  always_ff @(posedge clk_in) begin
    if (rs_push)  rs_mem[rs_wr_ptr]   <= '{rob_id: rs_rob_id,  data: rs_data,  jump: rs_set_jump_addr};
    if (lsb_push) lsb_mem[lsb_wr_ptr] <= '{rob_id: lsb_rob_id, data: lsb_data, jump: 1'b0};
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rs_wr_ptr         <= '0;
      rs_rd_ptr         <= '0;
      lsb_wr_ptr        <= '0;
      lsb_rd_ptr        <= '0;
      rs_count          <= '0;
      lsb_count         <= '0;
      last_grant        <= SRC_LSB;
      cdb_en            <= 1'b0;
      cdb_rob_id        <= '0;
      cdb_data          <= '0;
      cdb_set_jump_addr <= 1'b0;
      cdb_src           <= 1'b0;
    end else if (rdy_in) begin
      if (flush) begin
        rs_wr_ptr  <= '0;
        rs_rd_ptr  <= '0;
        lsb_wr_ptr <= '0;
        lsb_rd_ptr <= '0;
        rs_count   <= '0;
        lsb_count  <= '0;
        last_grant <= SRC_LSB;
        cdb_en     <= 1'b0;
      end else begin
        if (rs_push)  rs_wr_ptr  <= rs_wr_ptr  + PTR_W'(1);
        if (rs_pop)   rs_rd_ptr  <= rs_rd_ptr  + PTR_W'(1);
        if (lsb_push) lsb_wr_ptr <= lsb_wr_ptr + PTR_W'(1);
        if (lsb_pop)  lsb_rd_ptr <= lsb_rd_ptr + PTR_W'(1);

        if (rs_push && !rs_pop)      rs_count <= rs_count + CNT_W'(1);
        else if (!rs_push && rs_pop) rs_count <= rs_count - CNT_W'(1);

        if (lsb_push && !lsb_pop)      lsb_count <= lsb_count + CNT_W'(1);
        else if (!lsb_push && lsb_pop) lsb_count <= lsb_count - CNT_W'(1);

        if (grant_rs) begin
          cdb_en            <= 1'b1;
          cdb_rob_id        <= rs_head.rob_id;
          cdb_data          <= rs_head.data;
          cdb_set_jump_addr <= rs_head.jump;
          cdb_src           <= SRC_RS;
          last_grant        <= SRC_RS;
        end else if (grant_lsb) begin
          cdb_en            <= 1'b1;
          cdb_rob_id        <= lsb_head.rob_id;
          cdb_data          <= lsb_head.data;
          cdb_set_jump_addr <= 1'b0;
          cdb_src           <= SRC_LSB;
          last_grant        <= SRC_LSB;
        end else begin
          cdb_en <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a vector table for arbitration/backpressure plus
// hand-written sequences for flush, stall, pointer wrap and asynchronous reset.
module tb_cdb_arbiter;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        flush;
  logic        rs_valid;
  logic        rs_ready;
  logic [3:0]  rs_rob_id;
  logic [31:0] rs_data;
  logic        rs_set_jump_addr;
  logic        lsb_valid;
  logic        lsb_ready;
  logic [3:0]  lsb_rob_id;
  logic [31:0] lsb_data;
  logic        cdb_en;
  logic [3:0]  cdb_rob_id;
  logic [31:0] cdb_data;
  logic        cdb_set_jump_addr;
  logic        cdb_src;

  cdb_arbiter #(.ROB_WIDTH(4), .DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .flush             (flush),
    .rs_valid          (rs_valid),
    .rs_ready          (rs_ready),
    .rs_rob_id         (rs_rob_id),
    .rs_data           (rs_data),
    .rs_set_jump_addr  (rs_set_jump_addr),
    .lsb_valid         (lsb_valid),
    .lsb_ready         (lsb_ready),
    .lsb_rob_id        (lsb_rob_id),
    .lsb_data          (lsb_data),
    .cdb_en            (cdb_en),
    .cdb_rob_id        (cdb_rob_id),
    .cdb_data          (cdb_data),
    .cdb_set_jump_addr (cdb_set_jump_addr),
    .cdb_src           (cdb_src)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic        rs_v;
    logic [3:0]  rs_id;
    logic [31:0] rs_d;
    logic        rs_j;
    logic        lsb_v;
    logic [3:0]  lsb_id;
    logic [31:0] lsb_d;
    logic        e_rs_rdy;
    logic        e_lsb_rdy;
    logic        e_en;
    logic [3:0]  e_id;
    logic [31:0] e_d;
    logic        e_j;
    logic        e_src;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    else             n_pass++;
  endtask

  task automatic drive(input logic rv, input logic [3:0] rid, input logic [31:0] rd, input logic rj,
                       input logic lv, input logic [3:0] lid, input logic [31:0] ld);
    rs_valid         = rv;
    rs_rob_id        = rid;
    rs_data          = rd;
    rs_set_jump_addr = rj;
    lsb_valid        = lv;
    lsb_rob_id       = lid;
    lsb_data         = ld;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic expect_cdb(input string nm, input logic en, input logic [3:0] id,
                            input logic [31:0] d, input logic j, input logic src);
    check({nm, ".en"},   cdb_en,            en);
    check({nm, ".id"},   cdb_rob_id,        id);
    check({nm, ".data"}, cdb_data,          d);
    check({nm, ".jump"}, cdb_set_jump_addr, j);
    check({nm, ".src"},  cdb_src,           src);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    // rs_v id data j | lsb_v id data | rs_rdy lsb_rdy | en id data j src
    // Both producers push every cycle from reset; a refused offer is re-presented.
    vecs[0]  = '{1'b1, 4'd0, 32'h100, 1'b0, 1'b1, 4'd8,  32'h208, 1'b1, 1'b1, 1'b0, 4'd0,  32'h0,   1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'd1, 32'h101, 1'b1, 1'b1, 4'd9,  32'h209, 1'b1, 1'b1, 1'b1, 4'd0,  32'h100, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 4'd2, 32'h102, 1'b0, 1'b1, 4'd10, 32'h20A, 1'b1, 1'b1, 1'b1, 4'd8,  32'h208, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 4'd3, 32'h103, 1'b0, 1'b1, 4'd11, 32'h20B, 1'b1, 1'b1, 1'b1, 4'd1,  32'h101, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 4'd4, 32'h104, 1'b0, 1'b1, 4'd12, 32'h20C, 1'b1, 1'b1, 1'b1, 4'd9,  32'h209, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 4'd5, 32'h105, 1'b0, 1'b1, 4'd13, 32'h20D, 1'b1, 1'b1, 1'b1, 4'd2,  32'h102, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 4'd6, 32'h106, 1'b0, 1'b1, 4'd14, 32'h20E, 1'b1, 1'b0, 1'b1, 4'd10, 32'h20A, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 4'd7, 32'h107, 1'b0, 1'b1, 4'd14, 32'h20E, 1'b0, 1'b1, 1'b1, 4'd3,  32'h103, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 4'd7, 32'h107, 1'b0, 1'b1, 4'd15, 32'h20F, 1'b1, 1'b0, 1'b1, 4'd11, 32'h20B, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 4'd8, 32'h108, 1'b0, 1'b1, 4'd15, 32'h20F, 1'b0, 1'b1, 1'b1, 4'd4,  32'h104, 1'b0, 1'b0};
    // Drain: RS holds 5,6,7 and LSB holds 12..15.
    vecs[10] = '{1'b0, 4'd0, 32'h0,   1'b0, 1'b0, 4'd0,  32'h0,   1'b1, 1'b0, 1'b1, 4'd12, 32'h20C, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 4'd0, 32'h0,   1'b0, 1'b0, 4'd0,  32'h0,   1'b1, 1'b1, 1'b1, 4'd5,  32'h105, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 4'd0, 32'h0,   1'b0, 1'b0, 4'd0,  32'h0,   1'b1, 1'b1, 1'b1, 4'd13, 32'h20D, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 4'd0, 32'h0,   1'b0, 1'b0, 4'd0,  32'h0,   1'b1, 1'b1, 1'b1, 4'd6,  32'h106, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 4'd0, 32'h0,   1'b0, 1'b0, 4'd0,  32'h0,   1'b1, 1'b1, 1'b1, 4'd14, 32'h20E, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 4'd0, 32'h0,   1'b0, 1'b0, 4'd0,  32'h0,   1'b1, 1'b1, 1'b1, 4'd7,  32'h107, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 4'd0, 32'h0,   1'b0, 1'b0, 4'd0,  32'h0,   1'b1, 1'b1, 1'b1, 4'd15, 32'h20F, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 4'd0, 32'h0,   1'b0, 1'b0, 4'd0,  32'h0,   1'b1, 1'b1, 1'b0, 4'd15, 32'h20F, 1'b0, 1'b1};
    // Single RS push, minimum latency, then the pulse ends and fields hold.
    vecs[18] = '{1'b1, 4'd3, 32'h12345678, 1'b1, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1, 1'b0, 4'd15, 32'h20F, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1, 1'b1, 4'd3, 32'h12345678, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1, 1'b0, 4'd3, 32'h12345678, 1'b1, 1'b0};

    rst_in = 1'b1;
    rdy_in = 1'b1;
    flush  = 1'b0;
    idle();
    #2;
    expect_cdb("reset", 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    check("reset.rs_ready",  rs_ready,  1'b1);
    check("reset.lsb_ready", lsb_ready, 1'b1);
    tick();
    rst_in = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rs_v, vecs[i].rs_id, vecs[i].rs_d, vecs[i].rs_j,
            vecs[i].lsb_v, vecs[i].lsb_id, vecs[i].lsb_d);
      #1;
      check($sformatf("vec%0d.rs_ready", i),  rs_ready,  vecs[i].e_rs_rdy);
      check($sformatf("vec%0d.lsb_ready", i), lsb_ready, vecs[i].e_lsb_rdy);
      tick();
      expect_cdb($sformatf("vec%0d", i), vecs[i].e_en, vecs[i].e_id, vecs[i].e_d,
                 vecs[i].e_j, vecs[i].e_src);
    end

    // Flush: build RS {4,5,6} and LSB {11,12} queued with last grant = RS, then flush.
    drive(1'b1, 4'd1, 32'hA1, 1'b0, 1'b1, 4'd9,  32'hB9); tick();
    expect_cdb("fl_pre0", 1'b0, 4'd3, 32'h12345678, 1'b1, 1'b0);
    drive(1'b1, 4'd2, 32'hA2, 1'b0, 1'b1, 4'd10, 32'hBA); tick();
    expect_cdb("fl_pre1", 1'b1, 4'd9, 32'hB9, 1'b0, 1'b1);
    drive(1'b1, 4'd4, 32'hA4, 1'b0, 1'b1, 4'd11, 32'hBB); tick();
    expect_cdb("fl_pre2", 1'b1, 4'd1, 32'hA1, 1'b0, 1'b0);
    drive(1'b1, 4'd5, 32'hA5, 1'b0, 1'b0, 4'd0,  32'h0);  tick();
    expect_cdb("fl_pre3", 1'b1, 4'd10, 32'hBA, 1'b0, 1'b1);
    drive(1'b1, 4'd6, 32'hA6, 1'b0, 1'b1, 4'd12, 32'hBC); tick();
    expect_cdb("fl_pre4", 1'b1, 4'd2, 32'hA2, 1'b0, 1'b0);
    flush = 1'b1;
    drive(1'b1, 4'd7, 32'hA7, 1'b0, 1'b1, 4'd13, 32'hBD);
    #1;
    check("fl.rs_ready",  rs_ready,  1'b0);
    check("fl.lsb_ready", lsb_ready, 1'b0);
    tick();
    flush = 1'b0;
    idle();
    #1;
    check("fl_post.en",        cdb_en,    1'b0);
    check("fl_post.rs_ready",  rs_ready,  1'b1);
    check("fl_post.lsb_ready", lsb_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("fl_quiet%0d.en", i), cdb_en, 1'b0);
    end
    // Flush restored last_grant to LSB, so RS wins the next tie.
    drive(1'b1, 4'd3, 32'hA3, 1'b0, 1'b1, 4'd13, 32'hBD); tick();
    check("fl_tie0.en", cdb_en, 1'b0);
    idle(); tick();
    expect_cdb("fl_tie1", 1'b1, 4'd3, 32'hA3, 1'b0, 1'b0);
    tick();
    expect_cdb("fl_tie2", 1'b1, 4'd13, 32'hBD, 1'b0, 1'b1);
    tick();
    check("fl_tie3.en", cdb_en, 1'b0);

    // Stall: RS {5,6} queued while LSB 12 is on the bus, then rdy_in low for 3 cycles.
    drive(1'b1, 4'd4, 32'hA4, 1'b0, 1'b1, 4'd12, 32'hBC); tick();
    check("st_pre0.en", cdb_en, 1'b0);
    drive(1'b1, 4'd5, 32'hA5, 1'b0, 1'b0, 4'd0, 32'h0); tick();
    expect_cdb("st_pre1", 1'b1, 4'd4, 32'hA4, 1'b0, 1'b0);
    drive(1'b1, 4'd6, 32'hA6, 1'b0, 1'b0, 4'd0, 32'h0); tick();
    expect_cdb("st_pre2", 1'b1, 4'd12, 32'hBC, 1'b0, 1'b1);
    rdy_in = 1'b0;
    drive(1'b0, 4'd0, 32'h0, 1'b0, 1'b1, 4'd14, 32'hBE);
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      #1;
      check($sformatf("st%0d.rs_ready", i),  rs_ready,  1'b0);
      check($sformatf("st%0d.lsb_ready", i), lsb_ready, 1'b0);
      tick();
      expect_cdb($sformatf("st%0d", i), 1'b1, 4'd12, 32'hBC, 1'b0, 1'b1);
    end
    rdy_in = 1'b1;
    flush  = 1'b0;
    idle(); tick();
    expect_cdb("st_drain0", 1'b1, 4'd5, 32'hA5, 1'b0, 1'b0);
    tick();
    expect_cdb("st_drain1", 1'b1, 4'd6, 32'hA6, 1'b0, 1'b0);
    tick();
    expect_cdb("st_drain2", 1'b0, 4'd6, 32'hA6, 1'b0, 1'b0);

    // Ten back-to-back RS results cross the pointer wrap twice.
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 4'(k), 32'hC000_0000 + 32'(k), 1'b0, 1'b0, 4'd0, 32'h0);
      tick();
      if (k == 0) check("wrap0.en", cdb_en, 1'b0);
      else expect_cdb($sformatf("wrap%0d", k), 1'b1, 4'(k - 1), 32'hC000_0000 + 32'(k - 1), 1'b0, 1'b0);
    end
    idle(); tick();
    expect_cdb("wrap10", 1'b1, 4'd9, 32'hC000_0009, 1'b0, 1'b0);
    tick();
    check("wrap11.en", cdb_en, 1'b0);

    // Asynchronous reset with three entries queued on each side.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 4'(k), 32'hD000_0000 + 32'(k), 1'b0, 1'b1, 4'(8 + k), 32'hE000_0000 + 32'(k));
      tick();
    end
    check("rst_pre.en", cdb_en, 1'b1);
    idle();
    #2;
    rst_in = 1'b1;
    #1;
    expect_cdb("rst_mid", 1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
    check("rst_mid.rs_ready",  rs_ready,  1'b1);
    check("rst_mid.lsb_ready", lsb_ready, 1'b1);
    #1;
    rst_in = 1'b0;
    drive(1'b1, 4'd7, 32'hF7, 1'b1, 1'b0, 4'd0, 32'h0); tick();
    check("rst_post0.en", cdb_en, 1'b0);
    idle(); tick();
    expect_cdb("rst_post1", 1'b1, 4'd7, 32'hF7, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_quiet%0d.en", i), cdb_en, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
